// File: rtl/mult_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_sched
// Purpose  : Round-robin scheduler in front of one shared sequential
//            shift-add multiplier. In IDLE it picks the next requesting
//            client after the last one served. It latches that client's
//            operands and runs SIZE add/shift steps. It then presents the
//            unsigned product, tagged with the client id, on a valid/ready
//            result port.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active-high
//            req        - per-requester request level [N_REQ]
//            opa        - multiplicands, requester i at [i*SIZE +: SIZE]
//            opb        - multipliers, same packing as opa
//            ack        - one-hot pulse, operands of that requester captured
//            res_valid  - product available
//            res_data   - unsigned product opa*opb [2*SIZE]
//            res_id     - requester owning res_data [IDW]
//            res_ready  - consumer accepts result
//            busy       - scheduler not idle
// Revision : 1.0 - initial release
// ============================================================================
module mult_rr_sched #(
  parameter int SIZE  = 8,
  parameter int N_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*SIZE-1:0]   opa,
  input  logic [N_REQ*SIZE-1:0]   opb,
  output logic [N_REQ-1:0]        ack,
  output logic                    res_valid,
  output logic [2*SIZE-1:0]       res_data,
  output logic [$clog2(N_REQ)-1:0] res_id,
  input  logic                    res_ready,
  output logic                    busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW  = 2 * SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [IDW-1:0]    ptr;
  logic [CW-1:0]     cnt;
  logic [SIZE-1:0]   opa_q;
  logic [SIZE-1:0]   opb_q;
  logic [PW-1:0]     acc;

  logic [IDW-1:0]    winner;
  logic              found;
  logic [IDW:0]      scan;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     acc_next;
  logic              last_step;

  // Round-robin search starting at ptr. The scan index carries one extra bit
  // so that ptr+k can be folded back below N_REQ even when N_REQ is not a
  // power of two; ptr itself therefore never leaves 0..N_REQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(N_REQ)) begin
        scan = scan - (IDW+1)'(N_REQ);
      end
      if (!found && req[scan[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan[IDW-1:0];
      end
    end
  end

  // One shift-add step: multiplier bit cnt selects opa shifted by cnt.
  assign addend    = {{SIZE{1'b0}}, opa_q} << cnt;
  assign acc_next  = opb_q[cnt] ? (acc + addend) : acc;
  assign last_step = (cnt == CW'(SIZE - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (found)     state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: if (res_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc       <= '0;
      ack       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      // ack is a single-cycle pulse covering only the first RUN cycle.
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            opa_q  <= opa[int'(winner)*SIZE +: SIZE];
            opb_q  <= opb[int'(winner)*SIZE +: SIZE];
            acc    <= '0;
            cnt    <= '0;
            res_id <= winner;
            ack    <= N_REQ'(1) << winner;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            res_valid <= 1'b1;
            res_data  <= acc_next;
          end
        end
        DONE: begin
          // Next search starts just after the requester that was served.
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_id == IDW'(N_REQ - 1)) begin
              ptr <= '0;
            end else begin
              ptr <= res_id + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire
